// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: command encodings
// and the controller state enum.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_JMP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } seq_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO: DEPTH entries of AW bits, with a synchronously
// reset occupancy pointer. Entry contents are not reset.
module ras_stack #(
    parameter int AW    = 4,
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [DEPTH];
    logic [DW-1:0] ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign wr_idx  = IW'(ptr);
    assign top_idx = IW'(ptr - DW'(1));
    assign full    = (ptr == DW'(DEPTH));
    assign empty   = (ptr == '0);
    assign depth   = ptr;
    // Reading while empty would index past the live entries, so return zero.
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + DW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Controller that drives the load/data inputs of the program counter:
// boot vector, jump/call/return commands, stall/halt freeze and fault latch.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int            AW        = 4,
    parameter int            DEPTH     = 4,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int            DW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_q,
    input  logic          cmd_valid,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_target,
    output logic          cmd_ready,
    input  logic          stall,
    input  logic          halt_req,
    input  logic          resume,
    output logic          pc_load,
    output logic [AW-1:0] pc_data,
    output logic [DW-1:0] depth,
    output logic          halted,
    output logic          fault
);

    seq_state_t state, state_next;
    cmd_op_t    op;
    logic       push, pop, full, empty;
    logic [AW-1:0] top;

    assign op = cmd_op_t'(cmd_op);

    ras_stack #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q + AW'(1)),
        .top       (top),
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_BOOT;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= (state_next == ST_HALT);
            fault  <= (state_next == ST_FAULT);
        end
    end

    // Stack misuse only faults when the command is actually accepted.
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (!stall && cmd_valid) begin
                    if ((op == OP_CALL && full) || (op == OP_RET && empty)) begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_HALT:  if (resume) state_next = ST_RUN;
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_load   = 1'b0;
        pc_data   = '0;
        cmd_ready = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        if (!rst) begin
            case (state)
                ST_BOOT: begin
                    pc_load = 1'b1;
                    pc_data = RESET_VEC;
                end
                ST_RUN: begin
                    if (halt_req || stall) begin
                        pc_load = 1'b1;
                        pc_data = pc_q;
                    end else begin
                        cmd_ready = 1'b1;
                        if (cmd_valid) begin
                            case (op)
                                OP_JMP: begin
                                    pc_load = 1'b1;
                                    pc_data = cmd_target;
                                end
                                OP_CALL: begin
                                    pc_load = 1'b1;
                                    pc_data = full ? pc_q : cmd_target;
                                    push    = !full;
                                end
                                OP_RET: begin
                                    pc_load = 1'b1;
                                    pc_data = empty ? pc_q : top;
                                    pop     = !empty;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: begin
                    pc_load = 1'b1;
                    pc_data = pc_q;
                end
            endcase
        end
    end

endmodule
